mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Registers execute outputs (EX/MEM boundary) and performs load/store through a req/ack data-memory port with byte enables.
- Sign/zero-extends load data and registers results into MEM/WB outputs for writeback.
- Stalls upstream while a memory access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath width (fixed 32 for byte-lane logic)
ADDRESS_WIDTH, 32, address width
TIMEOUT_CYCLES, 255, max wait cycles for dmem_ack before bus error

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_e  input  1  execute-stage instruction valid
reg_write_e  input  1  register write enable
res_src_e  input  2  result select: 00 ALU, 01 load data, 10 pc+4
mem_write_e  input  1  store
funct3_e  input  3  access size/sign (funct3[14:12])
alu_result_e  input  DATA_WIDTH  effective address / ALU result
write_data_e  input  DATA_WIDTH  store data
rd_e  input  5  destination register
pc_plus4_e  input  ADDRESS_WIDTH  pc+4
stall_m  output  1  hold execute and earlier stages
dmem_req  output  1  memory request
dmem_we  output  1  write request
dmem_addr  output  ADDRESS_WIDTH  word-aligned address (addr[1:0]=00)
dmem_wdata  output  DATA_WIDTH  lane-aligned store data
dmem_be  output  4  byte enables
dmem_ack  input  1  request completed
dmem_rdata  input  DATA_WIDTH  read word
valid_w, reg_write_w  output  1 each  writeback valid / write enable
res_src_w  output  2  result select
alu_result_w, read_data_w  output  DATA_WIDTH  ALU result / extended load data
rd_w  output  5  destination
pc_plus4_w  output  ADDRESS_WIDTH  pc+4
misaligned_w, bus_err_w  output  1 each  exception flags

Behaviour:
- Reset: every registered output and internal register is 0, FSM is IDLE, counter is 0. stall_m=0, dmem_req=0.
- EX/MEM register: the *_m registers capture *_e every cycle with stall_m=0 and hold while stall_m=1.
- mem_op = valid_m & (mem_write_m | res_src_m==01).
- Alignment: halfword (funct3 x01) needs addr[0]=0. Word (010) needs addr[1:0]=0. A misaligned op issues no request.
- FSM IDLE:
  - Aligned mem_op: dmem_req=1 combinationally.
  - If dmem_ack arrives the same cycle, the op completes in one cycle with no stall.
  - Otherwise stall_m=1 and next state is WAIT.
- FSM WAIT:
  - dmem_req and all request signals are held stable. stall_m=1. Counter increments each cycle.
  - dmem_ack: complete, state goes to IDLE, counter clears.
  - Counter reaches TIMEOUT_CYCLES with no ack: abort. dmem_req drops, bus_err_w=1, state goes to IDLE.
- A late ack after abort is ignored.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: be=0011<<(2*addr[1]), wdata = half replicated ×2.
  - SW: be=1111.
- dmem_be=0000 on loads; dmem_we=mem_write_m.
- Load extraction uses addr[1:0]:
  - LB (000) and LH (001) sign-extend.
  - LW (010) passes the word.
  - LBU (100) and LHU (101) zero-extend.
  - Other funct3 return 0.
- MEM/WB register, per cycle:
  - Op completing or non-memory valid_m: load all *_w from *_m, read_data_w from the extracted data.
  - Stall cycle: valid_w=0, reg_write_w=0 (bubble); data fields don't care.
  - Misaligned or timeout: valid_w=1, reg_write_w=0, corresponding flag=1.
- Flags are single-cycle and clear on the next writeback.
- Reset mid-access: dmem_req drops in the cycle after rst asserts, and the in-flight op is discarded.
- Back-to-back memory ops: the next op's request is raised in the cycle after completion, with no dead cycle beyond the capture.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack same cycle -> dmem_be=1111, dmem_addr=0x100, stall_m never asserts, valid_w=1 next cycle.
- LB addr 0x203, rdata 0x80FF_FF7F, ack after 3 cycles -> stall_m high for 3 cycles, read_data_w=0xFFFFFF80, rd_w matches. LBU on the same inputs -> 0x00000080.
- SH addr 0x12, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD. LH addr 0x11 -> no dmem_req, misaligned_w=1, reg_write_w=0.
- Load with no ack for 255 cycles -> bus_err_w=1, dmem_req drops, stall_m releases. An ack arriving on cycle 260 has no effect.
- ADD (res_src 00) after an outstanding load -> ADD's *_e values held at the execute outputs (unchanged) until load ack, then appears at W one cycle after the load.
- rst asserted during WAIT -> next cycle all outputs 0, state IDLE, a fresh load afterwards completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM capture, req/ack data-memory access with byte lanes,
// load extension and MEM/WB capture. Holds upstream while an access is outstanding.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_e,
  input  logic                     reg_write_e,
  input  logic [1:0]               res_src_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     stall_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     valid_w,
  output logic                     reg_write_w,
  output logic [1:0]               res_src_w,
  output logic [DATA_WIDTH-1:0]    alu_result_w,
  output logic [DATA_WIDTH-1:0]    read_data_w,
  output logic [4:0]               rd_w,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_w,
  output logic                     misaligned_w,
  output logic                     bus_err_w
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;

  logic                       valid_m;
  logic                       reg_write_m;
  logic [1:0]                 res_src_m;
  logic                       mem_write_m;
  logic [2:0]                 funct3_m;
  logic [DATA_WIDTH-1:0]      alu_result_m;
  logic [DATA_WIDTH-1:0]      write_data_m;
  logic [4:0]                 rd_m;
  logic [ADDRESS_WIDTH-1:0]   pc_plus4_m;

  logic                       mem_op;
  logic                       aligned;
  logic                       misaligned;
  logic                       timeout;

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                         input logic [1:0] a,
                                                         input logic [DATA_WIDTH-1:0] w);
    logic signed [7:0]            sb;
    logic signed [15:0]           sh;
    logic signed [DATA_WIDTH-1:0] ext;
    sb = w[{a, 3'b000} +: 8];
    sh = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  ext = sb;
      3'b001:  ext = sh;
      3'b010:  ext = w;
      3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, sb};
      3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, sh};
      default: ext = '0;
    endcase
    return ext;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] sz,
                                                       input logic [DATA_WIDTH-1:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  always_comb begin
    mem_op  = valid_m & (mem_write_m | (res_src_m == 2'b01));
    case (funct3_m[1:0])
      2'b01:   aligned = ~alu_result_m[0];
      2'b10:   aligned = (alu_result_m[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    misaligned = mem_op & ~aligned;
    timeout    = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT_CYCLES));
    // In WAIT the request stays up (EX/MEM is frozen) until ack or timeout abort.
    dmem_req   = (state == S_IDLE) ? (mem_op & aligned) : ~timeout;
    stall_m    = dmem_req & ~dmem_ack;
    dmem_we    = mem_write_m;
    dmem_addr  = {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
    dmem_wdata = store_data(funct3_m[1:0], write_data_m);
    dmem_be    = mem_write_m ? store_be(funct3_m[1:0], alu_result_m[1:0]) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      res_src_m    <= '0;
      mem_write_m  <= 1'b0;
      funct3_m     <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      res_src_w    <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      rd_w         <= '0;
      pc_plus4_w   <= '0;
      misaligned_w <= 1'b0;
      bus_err_w    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (dmem_req && !dmem_ack) state <= S_WAIT;
        end
        default: begin
          if (timeout || dmem_ack) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // EX/MEM boundary
      if (!stall_m) begin
        valid_m      <= valid_e;
        reg_write_m  <= reg_write_e;
        res_src_m    <= res_src_e;
        mem_write_m  <= mem_write_e;
        funct3_m     <= funct3_e;
        alu_result_m <= alu_result_e;
        write_data_m <= write_data_e;
        rd_m         <= rd_e;
        pc_plus4_m   <= pc_plus4_e;
      end

      // MEM/WB boundary
      if (stall_m) begin
        valid_w      <= 1'b0;
        reg_write_w  <= 1'b0;
        misaligned_w <= 1'b0;
        bus_err_w    <= 1'b0;
      end else begin
        valid_w      <= valid_m;
        reg_write_w  <= reg_write_m & ~misaligned & ~timeout;
        res_src_w    <= res_src_m;
        alu_result_w <= alu_result_m;
        read_data_w  <= load_extract(funct3_m, alu_result_m[1:0], dmem_rdata);
        rd_w         <= rd_m;
        pc_plus4_w   <= pc_plus4_m;
        misaligned_w <= misaligned;
        bus_err_w    <= timeout;
      end
    end
  end

endmodule
